// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared types, constants and helpers for the memory tester
package rtl_settings_pkg;

  localparam int RDC_DATA_W     = 512;
  localparam int RDC_DATA_B_W   = RDC_DATA_W / 8;
  localparam int RDC_OFF_W      = $clog2(RDC_DATA_B_W);
  localparam int RDC_BURST_W    = 11;
  localparam int RDC_ADDR_W     = 26;
  localparam int RDC_FIFO_DEPTH = 8;
  localparam int RDC_CNT_W      = 32;

  localparam logic [7:0] LFSR_POLY = 8'hB8;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } data_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rdc_state_t;

  typedef struct packed {
    logic                   trans_type;  // 0 = read/compare, 1 = write
    data_mode_t             data_mode;
    logic [7:0]             data_ptrn;
    logic [RDC_ADDR_W-1:0]  start_addr;
    logic [RDC_BURST_W-2:0] words_count; // beats - 1
    logic [RDC_OFF_W-1:0]   start_off;
    logic [RDC_OFF_W-1:0]   end_off;
  } cmp_struct_t;

  function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // An all-zero state would lock the LFSR, so a zero pattern seeds with 0x01.
  function automatic logic [7:0] lfsr8_seed(input logic [7:0] ptrn);
    return (ptrn == 8'h00) ? 8'h01 : ptrn;
  endfunction

  function automatic logic [RDC_DATA_B_W-1:0] byteenable_ptrn(
    input logic                 first,
    input logic                 last,
    input logic [RDC_OFF_W-1:0] start_off,
    input logic [RDC_OFF_W-1:0] end_off
  );
    logic [RDC_DATA_B_W-1:0] be;
    for (int i = 0; i < RDC_DATA_B_W; i++) begin
      be[i] = (!first || (i >= int'(start_off))) && (!last || (i <= int'(end_off)));
    end
    return be;
  endfunction

endpackage

// File: rtl/rdc_cmd_fifo.sv
// rtl/rdc_cmd_fifo.sv - showahead synchronous FIFO of compare descriptors
module rdc_cmd_fifo
  import rtl_settings_pkg::*;
#(
  parameter int DEPTH = RDC_FIFO_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  cmp_struct_t data_i,
  input  logic        pop_i,
  output cmp_struct_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  cmp_struct_t    mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  assign data_o  = mem[rd_ptr[AW-1:0]];
  assign empty_o = (wr_ptr == rd_ptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rd_data_checker.sv
// rtl/rd_data_checker.sv - checks AMM readdata beats against queued compare descriptors
module rd_data_checker
  import rtl_settings_pkg::*;
#(
  parameter int DATA_W     = RDC_DATA_W,
  parameter int BURST_W    = RDC_BURST_W,
  parameter int ADDR_W     = RDC_ADDR_W,
  parameter int FIFO_DEPTH = RDC_FIFO_DEPTH,
  parameter int CNT_W      = RDC_CNT_W,
  localparam int DATA_B_W  = DATA_W / 8,
  localparam int OFF_W     = $clog2(DATA_B_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_start_i,
  input  logic              stop_on_err_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  cmp_struct_t       cmd_i,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              busy_o,
  output logic              err_flag_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [OFF_W-1:0]  err_off_o,
  output logic [7:0]        err_data_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  words_o,
  output logic              unexp_rd_o
);

  rdc_state_t          state, state_nxt;
  cmp_struct_t         act;
  cmp_struct_t         fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [BURST_W-2:0]  beat_idx;
  logic [7:0]          lfsr, lfsr_adv;
  logic                push, pop, beat, last_beat;
  logic [DATA_W-1:0]   exp_data;
  logic [DATA_B_W-1:0] lane_en, mis;

  logic                s1_valid;
  logic [DATA_B_W-1:0] s1_mis;
  logic [ADDR_W-1:0]   s1_addr;
  logic [DATA_W-1:0]   s1_data;
  logic [OFF_W-1:0]    fail_off;
  logic [7:0]          fail_byte;
  logic                freeze;

  assign push      = cmd_valid_i && cmd_ready_o && (cmd_i.trans_type == 1'b0) && !test_start_i;
  assign beat      = (state == BURST) && rd_valid_i;
  assign last_beat = beat && (beat_idx == act.words_count);
  assign pop       = !fifo_empty && !test_start_i && ((state == IDLE) || last_beat);

  rdc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (test_start_i),
    .push_i  (push),
    .data_i  (cmd_i),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = BURST;
      BURST:   if (last_beat && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (test_start_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      act        <= '0;
      beat_idx   <= '0;
      lfsr       <= '0;
      unexp_rd_o <= 1'b0;
    end else if (test_start_i) begin
      state      <= IDLE;
      act        <= '0;
      beat_idx   <= '0;
      lfsr       <= '0;
      unexp_rd_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        act      <= fifo_dout;
        beat_idx <= '0;
        lfsr     <= lfsr8_seed(fifo_dout.data_ptrn);
      end else if (beat) begin
        beat_idx <= beat_idx + 1'b1;
        lfsr     <= lfsr_adv;
      end
      if ((state == IDLE) && rd_valid_i) unexp_rd_o <= 1'b1;
    end
  end

  // The LFSR walks every lane of a beat, masked or not, so the next beat starts DATA_B_W steps on.
  always_comb begin
    logic [7:0] s;
    s        = lfsr;
    exp_data = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      exp_data[i*8 +: 8] = (act.data_mode == RND_DATA) ? s : act.data_ptrn;
      s = lfsr8_step(s);
    end
    lfsr_adv = s;
  end

  assign lane_en = byteenable_ptrn(beat_idx == '0, beat_idx == act.words_count,
                                   act.start_off, act.end_off);

  always_comb begin
    mis = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      mis[i] = lane_en[i] && (rd_data_i[i*8 +: 8] != exp_data[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_mis   <= '0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else if (test_start_i) begin
      s1_valid <= 1'b0;
      s1_mis   <= '0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_mis  <= mis;
        s1_addr <= act.start_addr + ADDR_W'(beat_idx);
        s1_data <= rd_data_i;
      end
    end
  end

  always_comb begin
    fail_off  = '0;
    fail_byte = '0;
    for (int i = DATA_B_W - 1; i >= 0; i--) begin
      if (s1_mis[i]) begin
        fail_off  = OFF_W'(i);
        fail_byte = s1_data[i*8 +: 8];
      end
    end
  end

  assign freeze = stop_on_err_i && err_flag_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_flag_o <= 1'b0;
      err_addr_o <= '0;
      err_off_o  <= '0;
      err_data_o <= '0;
      err_cnt_o  <= '0;
      words_o    <= '0;
    end else if (test_start_i) begin
      err_flag_o <= 1'b0;
      err_addr_o <= '0;
      err_off_o  <= '0;
      err_data_o <= '0;
      err_cnt_o  <= '0;
      words_o    <= '0;
    end else if (s1_valid && !freeze) begin
      if (words_o != '1) words_o <= words_o + 1'b1;
      if (|s1_mis) begin
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
        if (!err_flag_o) begin
          err_flag_o <= 1'b1;
          err_addr_o <= s1_addr;
          err_off_o  <= fail_off;
          err_data_o <= fail_byte;
        end
      end
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign busy_o      = !fifo_empty || (state == BURST) || s1_valid;

endmodule
